// File: rtl/cnvrow_ctrl_pkg.sv
// Shared definitions for the CNVROW row sequencer: FSM encoding, default
// geometry and the log2 helper macro used to size the pixel index.
`ifndef C_LOG_2
`define C_LOG_2(n) (((n) > 1) ? $clog2(n) : 1)
`endif

package cnvrow_ctrl_pkg;

    localparam int LENROW = 16;
    localparam int BLK_W  = 8;
    localparam int ROW_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_MAC    = 3'd2,
        ST_ACC    = 3'd3,
        ST_ROWEND = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/cnvrow_ctrl_fnh_join.sv
// Sticky collector for the three MACAW finish pulses; all_fnh rises in the
// cycle the last outstanding finish arrives, and the flags clear themselves.
module fnh_join (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic fnh0,
    input  logic fnh1,
    input  logic fnh2,
    output logic all_fnh
);
    import cnvrow_ctrl_pkg::*;

    logic [2:0] flag_q;
    logic [2:0] hit;

    assign hit     = flag_q | {fnh2, fnh1, fnh0};
    assign all_fnh = en & (&hit);

    // Repeated finishes just re-set an already set flag, so duplicates are harmless.
    always_ff @(posedge clk) begin
        if (rst || clr || all_fnh) begin
            flag_q <= 3'b000;
        end else if (en) begin
            flag_q <= hit;
        end
    end

endmodule

// File: rtl/cnvrow_ctrl.sv
// Row sequencer for one CNVROW convolution-row datapath: walks blocks per pixel,
// pixels per row and rows per job, issuing MACAW starts and psum-shift pulses.
module cnvrow_ctrl #(
    parameter int LENROW = cnvrow_ctrl_pkg::LENROW,
    parameter int BLK_W  = cnvrow_ctrl_pkg::BLK_W,
    parameter int ROW_W  = cnvrow_ctrl_pkg::ROW_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          CTRL_Sta,
    input  logic [BLK_W-1:0]              CfgNumBlk,
    input  logic [ROW_W-1:0]              CfgNumRow,
    input  logic                          BUF_Rdy,
    input  logic                          PsumIn_Vld,
    input  logic                          MACPEC_Fnh0,
    input  logic                          MACPEC_Fnh1,
    input  logic                          MACPEC_Fnh2,
    output logic                          PECMAC_Sta,
    output logic                          PECCNV_PlsAcc,
    output logic                          PECCNV_FnhRow,
    output logic                          BUF_Req,
    output logic [ROW_W-1:0]              RowIdx,
    output logic [`C_LOG_2(LENROW)-1:0]   PixIdx,
    output logic [BLK_W-1:0]              BlkIdx,
    output logic                          PsumOut_Vld,
    output logic                          CTRL_Busy,
    output logic                          CTRL_Fnh
);
    import cnvrow_ctrl_pkg::*;

    localparam int PIX_W = `C_LOG_2(LENROW);

    state_t             state_q, state_d;
    logic [BLK_W-1:0]   num_blk_q, blk_q;
    logic [ROW_W-1:0]   num_row_q, row_q;
    logic [PIX_W-1:0]   pix_q;
    logic               sta_q;
    logic               all_fnh;
    logic               blk_last, pix_last, row_last;

    fnh_join u_fnh_join (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == ST_MAC),
        .clr     (state_q != ST_MAC),
        .fnh0    (MACPEC_Fnh0),
        .fnh1    (MACPEC_Fnh1),
        .fnh2    (MACPEC_Fnh2),
        .all_fnh (all_fnh)
    );

    // Comparisons use >= so a counter can never run past its configured limit.
    assign blk_last = (blk_q >= num_blk_q - BLK_W'(1));
    assign pix_last = (pix_q >= PIX_W'(LENROW - 1));
    assign row_last = (row_q >= num_row_q - ROW_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (CTRL_Sta)   state_d = ST_LOAD;
            ST_LOAD:   if (BUF_Rdy)    state_d = ST_MAC;
            ST_MAC:    if (all_fnh)    state_d = blk_last ? ST_ACC : ST_LOAD;
            ST_ACC:    if (PsumIn_Vld) state_d = pix_last ? ST_ROWEND : ST_LOAD;
            ST_ROWEND:                 state_d = row_last ? ST_DONE : ST_LOAD;
            ST_DONE:                   state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // A zero block/row count is latched as one so every job makes progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_blk_q <= '0;
            num_row_q <= '0;
            blk_q     <= '0;
            pix_q     <= '0;
            row_q     <= '0;
            sta_q     <= 1'b0;
        end else begin
            sta_q <= (state_q == ST_LOAD) && BUF_Rdy;
            case (state_q)
                ST_IDLE: begin
                    if (CTRL_Sta) begin
                        num_blk_q <= (CfgNumBlk == '0) ? BLK_W'(1) : CfgNumBlk;
                        num_row_q <= (CfgNumRow == '0) ? ROW_W'(1) : CfgNumRow;
                        blk_q     <= '0;
                        pix_q     <= '0;
                        row_q     <= '0;
                    end
                end
                ST_MAC: begin
                    if (all_fnh && !blk_last) begin
                        blk_q <= blk_q + BLK_W'(1);
                    end
                end
                ST_ACC: begin
                    if (PsumIn_Vld) begin
                        blk_q <= '0;
                        if (!pix_last) begin
                            pix_q <= pix_q + PIX_W'(1);
                        end
                    end
                end
                ST_ROWEND: begin
                    pix_q <= '0;
                    if (!row_last) begin
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign PECMAC_Sta    = sta_q;
    assign BUF_Req       = (state_q == ST_LOAD);
    assign PECCNV_PlsAcc = (state_q == ST_ACC) && PsumIn_Vld;
    assign PECCNV_FnhRow = (state_q == ST_ROWEND);
    assign CTRL_Fnh      = (state_q == ST_DONE);
    assign CTRL_Busy     = (state_q == ST_LOAD) || (state_q == ST_MAC) ||
                           (state_q == ST_ACC)  || (state_q == ST_ROWEND);
    // Row 0 shifts out the previous job's leftovers, so only later rows are real.
    assign PsumOut_Vld   = PECCNV_PlsAcc && (row_q != '0);
    assign RowIdx        = row_q;
    assign PixIdx        = pix_q;
    assign BlkIdx        = blk_q;

endmodule

// File: tb/tb_cnvrow_ctrl.sv
// Scoreboard bench for cnvrow_ctrl: jobs push their expected event stream,
// a monitor pops and compares each Sta/PlsAcc/FnhRow/Fnh the DUT presents.
module tb_cnvrow_ctrl;

    localparam int LEN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       CTRL_Sta;
    logic [7:0] CfgNumBlk;
    logic [7:0] CfgNumRow;
    logic       BUF_Rdy;
    logic       PsumIn_Vld;
    logic       MACPEC_Fnh0, MACPEC_Fnh1, MACPEC_Fnh2;
    logic       PECMAC_Sta, PECCNV_PlsAcc, PECCNV_FnhRow, BUF_Req;
    logic [7:0] RowIdx;
    logic [1:0] PixIdx;
    logic [7:0] BlkIdx;
    logic       PsumOut_Vld, CTRL_Busy, CTRL_Fnh;

    cnvrow_ctrl #(.LENROW(LEN), .BLK_W(8), .ROW_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .CTRL_Sta      (CTRL_Sta),
        .CfgNumBlk     (CfgNumBlk),
        .CfgNumRow     (CfgNumRow),
        .BUF_Rdy       (BUF_Rdy),
        .PsumIn_Vld    (PsumIn_Vld),
        .MACPEC_Fnh0   (MACPEC_Fnh0),
        .MACPEC_Fnh1   (MACPEC_Fnh1),
        .MACPEC_Fnh2   (MACPEC_Fnh2),
        .PECMAC_Sta    (PECMAC_Sta),
        .PECCNV_PlsAcc (PECCNV_PlsAcc),
        .PECCNV_FnhRow (PECCNV_FnhRow),
        .BUF_Req       (BUF_Req),
        .RowIdx        (RowIdx),
        .PixIdx        (PixIdx),
        .BlkIdx        (BlkIdx),
        .PsumOut_Vld   (PsumOut_Vld),
        .CTRL_Busy     (CTRL_Busy),
        .CTRL_Fnh      (CTRL_Fnh)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 Sta, 1 PlsAcc, 2 FnhRow, 3 CTRL_Fnh
        int row;
        int pix;
        int blk;
        int pvld;
        int gap;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  d0, d1, d2;
    bit  stall = 1'b0;
    bit  fnh_seen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected event stream of one job, derived from the job's dimensions.
    task automatic pushJob(input int nb, input int nr, input bit stl);
        int eb, er, maxd;
        ev_t e;
        eb   = (nb == 0) ? 1 : nb;
        er   = (nr == 0) ? 1 : nr;
        maxd = (d0 > d1) ? d0 : d1;
        maxd = (d2 > maxd) ? d2 : maxd;
        for (int r = 0; r < er; r++) begin
            for (int p = 0; p < LEN; p++) begin
                for (int b = 0; b < eb; b++) begin
                    e = '{0, r, p, b, 0, (b > 0 && !stl) ? maxd + 2 : -1};
                    sb.push_back(e);
                end
                e = '{1, r, p, 0, (r != 0) ? 1 : 0, -1};
                sb.push_back(e);
            end
            e = '{2, r, LEN - 1, 0, 0, -1};
            sb.push_back(e);
        end
        e = '{3, 0, 0, 0, 0, -1};
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input int nb, input int nr, input int fd0, input int fd1,
                                 input int fd2, input bit stl, input bit poke);
        d0 = fd0; d1 = fd1; d2 = fd2; stall = stl;
        pushJob(nb, nr, stl);
        fnh_seen = 1'b0;
        @(negedge clk);
        CfgNumBlk = 8'(nb);
        CfgNumRow = 8'(nr);
        CTRL_Sta  = 1'b1;
        @(negedge clk);
        CTRL_Sta  = 1'b0;
        CfgNumBlk = 8'd7;
        CfgNumRow = 8'd5;
        checkOutput("busy_after_sta", {31'd0, CTRL_Busy}, 32'd1);
        if (poke) begin
            repeat (2) @(negedge clk);
            CTRL_Sta  = 1'b1;
            CfgNumBlk = 8'd3;
            CfgNumRow = 8'd2;
            @(negedge clk);
            CTRL_Sta  = 1'b0;
        end
        for (int i = 0; i < 5000 && !fnh_seen; i++) @(negedge clk);
        if (!fnh_seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL job_timeout actual=no CTRL_Fnh required=CTRL_Fnh within 5000 cycles");
        end
        @(negedge clk);
        checkOutput("queue_drained", sb.size(), 32'd0);
        checkOutput("idle_busy", {31'd0, CTRL_Busy}, 32'd0);
        sb.delete();
        stall = 1'b0;
    endtask

    // MACAW model and buffer/psum drivers; protocol checks read inputs before updating them.
    initial begin
        int  cyc, sta_cyc, maxd, reqcnt, vcnt;
        bit  act, prev_req;
        cyc = 0; sta_cyc = 0; act = 0; reqcnt = 0; vcnt = 0; prev_req = 0;
        MACPEC_Fnh0 = 0; MACPEC_Fnh1 = 0; MACPEC_Fnh2 = 0;
        BUF_Rdy = 1'b1; PsumIn_Vld = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (stall && !rst) begin
                if (PECMAC_Sta)    checkOutput("sta_after_rdy", {31'd0, BUF_Rdy}, 32'd1);
                if (PECCNV_PlsAcc) checkOutput("acc_with_vld", {31'd0, PsumIn_Vld}, 32'd1);
                if (prev_req && !BUF_Rdy) checkOutput("req_held", {31'd0, BUF_Req}, 32'd1);
            end
            prev_req = BUF_Req;
            reqcnt   = BUF_Req ? reqcnt + 1 : 0;
            vcnt     = (vcnt + 1) % 6;
            BUF_Rdy    = stall ? (reqcnt > 7) : 1'b1;
            PsumIn_Vld = stall ? (vcnt == 5) : 1'b1;
            if (rst) begin
                act = 0;
                MACPEC_Fnh0 = 0; MACPEC_Fnh1 = 0; MACPEC_Fnh2 = 0;
            end else begin
                if (PECMAC_Sta) begin
                    act = 1;
                    sta_cyc = cyc;
                end
                maxd = (d0 > d1) ? d0 : d1;
                maxd = (d2 > maxd) ? d2 : maxd;
                MACPEC_Fnh0 = act && (cyc - sta_cyc == d0);
                MACPEC_Fnh1 = act && (cyc - sta_cyc == d1);
                MACPEC_Fnh2 = act && (cyc - sta_cyc == d2);
                if (act && cyc - sta_cyc >= maxd) act = 0;
            end
        end
    end

    // Monitor: pops one expected event for each event the DUT presents.
    initial begin
        int  mcyc, last_sta;
        ev_t e;
        mcyc = 0; last_sta = 0;
        forever begin
            @(negedge clk);
            mcyc++;
            if (!rst) begin
                for (int k = 0; k < 4; k++) begin
                    if ((k == 0 && PECMAC_Sta) || (k == 1 && PECCNV_PlsAcc) ||
                        (k == 2 && PECCNV_FnhRow) || (k == 3 && CTRL_Fnh)) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_event actual=kind %0d required=no event", k);
                        end else begin
                            e = sb.pop_front();
                            checkOutput("event_kind", k, e.kind);
                            if (k == 0) begin
                                checkOutput("sta_row", RowIdx, e.row);
                                checkOutput("sta_pix", PixIdx, e.pix);
                                checkOutput("sta_blk", BlkIdx, e.blk);
                                if (e.gap >= 0) checkOutput("sta_gap", mcyc - last_sta, e.gap);
                                last_sta = mcyc;
                            end else if (k == 1) begin
                                checkOutput("acc_row", RowIdx, e.row);
                                checkOutput("acc_pix", PixIdx, e.pix);
                                checkOutput("acc_psumout", {31'd0, PsumOut_Vld}, e.pvld);
                                checkOutput("acc_busy", {31'd0, CTRL_Busy}, 32'd1);
                            end else if (k == 2) begin
                                checkOutput("rowend_row", RowIdx, e.row);
                                checkOutput("rowend_busy", {31'd0, CTRL_Busy}, 32'd1);
                            end else begin
                                checkOutput("done_busy", {31'd0, CTRL_Busy}, 32'd0);
                                fnh_seen = 1'b1;
                            end
                        end
                    end
                end
                if (PsumOut_Vld && !PECCNV_PlsAcc)
                    checkOutput("psumout_stray", {31'd0, PsumOut_Vld}, 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_sta"},    {31'd0, PECMAC_Sta},    32'd0);
        checkOutput({tag, "_req"},    {31'd0, BUF_Req},       32'd0);
        checkOutput({tag, "_plsacc"}, {31'd0, PECCNV_PlsAcc}, 32'd0);
        checkOutput({tag, "_fnhrow"}, {31'd0, PECCNV_FnhRow}, 32'd0);
        checkOutput({tag, "_psumout"},{31'd0, PsumOut_Vld},   32'd0);
        checkOutput({tag, "_busy"},   {31'd0, CTRL_Busy},     32'd0);
        checkOutput({tag, "_fnh"},    {31'd0, CTRL_Fnh},      32'd0);
        checkOutput({tag, "_row"},    RowIdx,                 32'd0);
        checkOutput({tag, "_pix"},    PixIdx,                 32'd0);
        checkOutput({tag, "_blk"},    BlkIdx,                 32'd0);
    endtask

    initial begin
        bit hit;
        rst = 1'b1; CTRL_Sta = 1'b0; CfgNumBlk = 8'd1; CfgNumRow = 8'd1;
        d0 = 1; d1 = 1; d2 = 1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        $display("[TB] basic single-block single-row job");
        applyStimulus(1, 1, 3, 3, 3, 1'b0, 1'b0);
        $display("[TB] three blocks, staggered finishes");
        applyStimulus(3, 1, 2, 5, 3, 1'b0, 1'b0);
        $display("[TB] two rows, psum out on second row");
        applyStimulus(1, 2, 1, 1, 1, 1'b0, 1'b0);
        $display("[TB] buffer and psum stalls");
        applyStimulus(2, 1, 1, 2, 1, 1'b1, 1'b0);
        $display("[TB] finishes in the start cycle");
        applyStimulus(2, 1, 0, 1, 0, 1'b0, 1'b0);

        $display("[TB] reset during MAC of pixel 2");
        d0 = 2; d1 = 1; d2 = 2; stall = 1'b0;
        pushJob(2, 1, 1'b0);
        @(negedge clk);
        CfgNumBlk = 8'd2; CfgNumRow = 8'd1; CTRL_Sta = 1'b1;
        @(negedge clk);
        CTRL_Sta = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk);
            hit = PECMAC_Sta && (PixIdx == 2'd2);
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL reset_wait actual=no pixel 2 start required=pixel 2 start");
        end
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midrst");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1, 1, 1, 1, 1, 1'b0, 1'b0);

        $display("[TB] start during busy, zero config");
        applyStimulus(0, 0, 1, 2, 1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
